// File: rtl/demux_rr_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the round-robin demux scheduler.
package demux_rr_scheduler_pkg;

  localparam int unsigned NCH             = 8;
  localparam int unsigned SELW            = 3;
  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 16;
  localparam logic [7:0]  DROP_MAX        = 8'hFF;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] idx);
    return NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_rr_scheduler_rr_pick8.sv
// Combinational round-robin finder: first enabled channel after i_last_grant, wrapping 7->0.
module rr_pick8
  import demux_rr_scheduler_pkg::*;
(
  input  logic [NCH-1:0]  i_en_mask,
  input  logic [SELW-1:0] i_last_grant,
  output logic [SELW-1:0] o_index,
  output logic            o_any
);

  logic [SELW-1:0] w_cand;
  logic            w_found;

  // last_grant itself is the final candidate (k == NCH wraps back onto it)
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    o_index = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_cand = i_last_grant + SELW'(k);
      if (!w_found && i_en_mask[w_cand]) begin
        o_index = w_cand;
        w_found = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Single-word holding scheduler feeding a 1x8 demux; destinations picked round-robin over
// enabled channels, held words dropped after TIMEOUT cycles without delivery.
module demux_rr_scheduler
  import demux_rr_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [NCH-1:0]   en_mask,
  input  logic [NCH-1:0]   out_ready,
  output logic [NCH-1:0]   out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  select,
  output logic [7:0]       drop_cnt
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [SELW-1:0]  r_sel, w_sel_d;
  logic [SELW-1:0]  r_last, w_last_d;
  logic [7:0]       r_wait, w_wait_d;
  logic [7:0]       r_drop, w_drop_d;

  logic             w_hold;
  logic             w_fire;
  logic             w_expire;
  logic             w_accept;
  logic [SELW-1:0]  w_pick_idx;
  logic             w_pick_any;

  rr_pick8 u_rr_pick8 (
    .i_en_mask    (en_mask),
    .i_last_grant (r_last),
    .o_index      (w_pick_idx),
    .o_any        (w_pick_any)
  );

  assign w_hold   = (r_state == StHold);
  assign w_fire   = w_hold && out_ready[r_sel];
  assign w_expire = w_hold && !w_fire && (r_wait == WaitLast);
  // a slot frees up in the same cycle the held word leaves, allowing 1 word/cycle
  assign in_ready = w_pick_any && (!w_hold || w_fire || w_expire);
  assign w_accept = in_valid && in_ready;

  assign out_valid = w_hold ? onehot(r_sel) : '0;
  assign out_data  = r_data;
  assign select    = r_sel;
  assign drop_cnt  = r_drop;

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_sel_d   = r_sel;
    w_last_d  = r_last;
    w_wait_d  = r_wait;
    w_drop_d  = r_drop;

    if (w_expire && (r_drop != DROP_MAX)) begin
      w_drop_d = r_drop + 8'd1;
    end

    if (w_accept) begin
      w_state_d = StHold;
      w_data_d  = in_data;
      w_sel_d   = w_pick_idx;
      w_last_d  = w_pick_idx;
      w_wait_d  = '0;
    end else if (w_fire || w_expire) begin
      w_state_d = StIdle;
      w_wait_d  = '0;
    end else if (w_hold) begin
      w_wait_d  = r_wait + 8'd1;
    end
  end

  // last grant resets to 7 so the first word after reset goes to the lowest enabled channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= SELW'(NCH - 1);
      r_wait  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_sel   <= w_sel_d;
      r_last  <= w_last_d;
      r_wait  <= w_wait_d;
      r_drop  <= w_drop_d;
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: directed scenarios plus randomized model check.
module tb_demux_rr_scheduler;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic         clk, rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data, out_data;
  logic [7:0]   en_mask, out_ready, out_valid, drop_cnt;
  logic [2:0]   select;

  int n_checks, n_fail;

  // reference model state
  bit         m_held;
  int         m_dst, m_last, m_wait, m_drops;
  logic [7:0] m_data;

  demux_rr_scheduler #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .select    (select),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] en,
                       input logic [7:0] rdy);
    in_valid  = v;
    in_data   = d;
    en_mask   = en;
    out_ready = rdy;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rr_ref(input logic [7:0] en, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (en[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 8'h00) begin
      n_fail++; $display("FAIL reset_out_valid: got %h expected 00", out_valid);
    end
    n_checks++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data);
    end
    n_checks++;
    if (select !== 3'd0) begin
      n_fail++; $display("FAIL reset_select: got %0d expected 0", select);
    end
    n_checks++;
    if (drop_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_drop_cnt: got %h expected 00", drop_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream_all;
    logic [7:0] exp_v;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, 8'hA0 + 8'(i), 8'hFF, 8'hFF);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      if (i > 0) begin
        exp_v = 8'(1 << ((i - 1) % 8));
        n_checks++;
        if (out_valid !== exp_v || out_data !== 8'hA0 + 8'(i - 1)) begin
          n_fail++;
          $display("FAIL stream_word[%0d]: got valid %h data %h expected valid %h data %h",
                   i - 1, out_valid, out_data, exp_v, 8'hA0 + 8'(i - 1));
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (out_valid !== 8'h00) begin
      n_fail++; $display("FAIL stream_idle_after: got %h expected 00", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_two_channels;
    int exp_ch[4];
    exp_ch = '{2, 5, 2, 5};
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      drive(i < 4, 8'h10 + 8'(i), 8'b0010_0100, 8'hFF);
      #1;
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 8'(1 << exp_ch[i - 1]) || select !== 3'(exp_ch[i - 1])) begin
          n_fail++;
          $display("FAIL two_ch_word[%0d]: got valid %h select %0d expected channel %0d",
                   i - 1, out_valid, select, exp_ch[i - 1]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    do_reset();
    drive(1'b1, 8'h33, 8'h08, 8'h00);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 8'h44, 8'h08, (c == 3) ? 8'h08 : 8'hF7);
      #1;
      n_checks++;
      if (out_valid !== 8'h08 || out_data !== 8'h33 || in_ready !== (c == 3)) begin
        n_fail++;
        $display("FAIL stall[%0d]: got valid %h data %h ready %b expected 08 33 %b",
                 c, out_valid, out_data, in_ready, c == 3);
      end
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 8'h08, 8'h00);
    #1;
    n_checks++;
    if (out_valid !== 8'h08 || out_data !== 8'h44) begin
      n_fail++;
      $display("FAIL stall_next: got valid %h data %h expected 08 44", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    do_reset();
    drive(1'b1, 8'hAA, 8'hFF, 8'h00);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'hFF, 8'h00);
    for (int c = 0; c < int'(TO); c++) begin
      #1;
      n_checks++;
      if (out_valid !== 8'h01 || drop_cnt !== 8'h00 || in_ready !== (c == int'(TO) - 1)) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: got valid %h drops %0d ready %b", c, out_valid,
                 drop_cnt, in_ready);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (out_valid !== 8'h00 || drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_drop: got valid %h drops %0d expected 00 1", out_valid, drop_cnt);
    end
    drive(1'b1, 8'h55, 8'hFF, 8'h00);
    repeat (300 * TO + 4) @(negedge clk);
    #1;
    n_checks++;
    if (drop_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL timeout_saturate: got %0d expected 255", drop_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_mask_change;
    do_reset();
    drive(1'b1, 8'h5A, 8'h02, 8'h00);
    @(negedge clk);
    drive(1'b1, 8'h66, 8'hFD, 8'h00);
    #1;
    n_checks++;
    if (out_valid !== 8'h02 || select !== 3'd1 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL mask_keep: got valid %h select %0d data %h expected 02 1 5a", out_valid,
               select, out_data);
    end
    @(negedge clk);
    drive(1'b1, 8'h66, 8'h00, 8'h00);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 8'h02) begin
      n_fail++;
      $display("FAIL mask_zero: got ready %b valid %h expected 0 02", in_ready, out_valid);
    end
    @(negedge clk);
    drive(1'b1, 8'h66, 8'h00, 8'hFF);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 8'h02) begin
      n_fail++;
      $display("FAIL mask_zero_fire: got ready %b valid %h expected 0 02", in_ready, out_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 8'h00) begin
      n_fail++; $display("FAIL mask_delivered: got %h expected 00", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    drive(1'b1, 8'h11, 8'hFF, 8'hFF);
    @(negedge clk);
    drive(1'b1, 8'h22, 8'hFF, 8'hFF);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'hFF, 8'h00);
    #1;
    n_checks++;
    if (out_valid !== 8'h02) begin
      n_fail++; $display("FAIL rst_hold_setup: got %h expected 02", out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 8'h00 || drop_cnt !== 8'h00 || select !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_async: got valid %h drops %0d select %0d expected 00 0 0", out_valid,
               drop_cnt, select);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'h33, 8'hFF, 8'hFF);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'hFF, 8'h00);
    #1;
    n_checks++;
    if (out_valid !== 8'h01 || out_data !== 8'h33 || drop_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_next_word: got valid %h data %h drops %0d expected 01 33 0", out_valid,
               out_data, drop_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] en, rdy, d, exp_ov;
    logic       v;
    bit         fire, expire, exp_rdy, accept;
    m_held = 0; m_dst = 0; m_last = 7; m_wait = 0; m_drops = 0; m_data = 8'h00;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      en  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      rdy = 8'($urandom & $urandom & $urandom);
      d   = 8'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      drive(v, d, en, rdy);
      #1;
      fire    = m_held && rdy[m_dst];
      expire  = m_held && !fire && (m_wait == int'(TO) - 1);
      exp_rdy = (en != 8'h00) && (!m_held || fire || expire);
      exp_ov  = m_held ? 8'(1 << m_dst) : 8'h00;
      n_checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_ov || drop_cnt !== 8'(m_drops)) begin
        n_fail++;
        $display("FAIL random[%0d]: got ready %b valid %h drops %0d expected %b %h %0d", c,
                 in_ready, out_valid, drop_cnt, exp_rdy, exp_ov, m_drops);
      end
      if (m_held) begin
        n_checks++;
        if (out_data !== m_data || select !== 3'(m_dst)) begin
          n_fail++;
          $display("FAIL random_data[%0d]: got data %h select %0d expected %h %0d", c,
                   out_data, select, m_data, m_dst);
        end
      end
      accept = v && exp_rdy;
      if (expire && m_drops < 255) m_drops++;
      if (accept) begin
        m_dst  = rr_ref(en, m_last);
        m_last = m_dst;
        m_data = d;
        m_held = 1;
        m_wait = 0;
      end else if (fire || expire) begin
        m_held = 0;
        m_wait = 0;
      end else if (m_held) begin
        m_wait++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_stream_all();
    test_two_channels();
    test_stall();
    test_timeout();
    test_mask_change();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Parameter: TIMEOUT, default 16, cycles a held word waits for its destination before being dropped (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream word available.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  scheduler accepts a word this cycle; a transfer occurs when in_valid && in_ready.
REQ-008 en_mask  input  8  per-channel enable; bit k=1 makes channel k eligible.
REQ-009 out_ready  input  8  per-channel downstream ready.
REQ-010 out_valid  output  8  one-hot valid toward the 8 demux outputs; all zero when no word is held.
REQ-011 out_data  output  WIDTH  held word, common to all channels.
REQ-012 select  output  3  index of the current destination; drives the 1x8 demux select.
REQ-013 drop_cnt  output  8  saturating count of words dropped on timeout.

Function
REQ-014 FSM states: IDLE (no word held) and HOLD (one word held for channel select).
REQ-015 Out fire: HOLD && out_ready[select]; completes delivery at that edge.
REQ-016 in_ready = (en_mask != 0) && (IDLE || out fire || timeout expiry this cycle), combinational.
REQ-017 On input transfer: latch in_data into out_data, latch destination into select, set last_grant = destination, enter or stay in HOLD, clear wait counter.
REQ-018 Destination: first channel with en_mask bit set, searching last_grant+1, last_grant+2, ... modulo 8 (wrap 7->0); last_grant itself is searched last.
REQ-019 Latency: word accepted at edge N shows out_valid[select]=1 from cycle N+1; back-to-back accept allowed, giving 1 word/cycle when destinations are ready.
REQ-020 out_valid = HOLD ? (1 << select) : 8'h00; out_data and select stable while HOLD and not fired.
REQ-021 Destination is fixed once latched; en_mask changes during HOLD do not redirect or cancel the held word.
REQ-022 Wait counter increments each HOLD cycle without out fire; when it reaches TIMEOUT-1 with no fire, the word is discarded at that edge, drop_cnt increments (saturates at 255), FSM goes to IDLE unless a new word is accepted that same edge.
REQ-023 Out fire and timeout in the same cycle: fire wins, no drop.
REQ-024 Out fire with no new input: return to IDLE; out_valid 0 next cycle.
REQ-025 en_mask == 0: in_ready 0, any held word continues delivery or timeout normally.
REQ-026 last_grant updates only on input transfer, never on drop or fire.

Reset
REQ-027 rst=1 forces immediately: state IDLE, out_valid 0, out_data 0, select 0, drop_cnt 0, wait counter 0, last_grant 7 (first grant goes to lowest enabled channel from 0).
REQ-028 Reset mid-HOLD discards the held word without counting it as a drop.

Structure
REQ-029 Shared package holds NCH=8, SELW=3, IDLE/HOLD state encodings, default WIDTH and TIMEOUT.
REQ-030 Sub-module rr_pick8: combinational round-robin finder (inputs en_mask, last_grant; outputs index, any); instantiated once.

Verification
REQ-031 Reset, en_mask=FF, all out_ready=1, stream 8 words A0..A7 -> delivered one per cycle on channels 0,1,...,7, then wrap to 0; in_ready continuously 1.
REQ-032 en_mask=8'b0010_0100, out_ready=FF, 4 words -> channels 2,5,2,5.
REQ-033 Word to channel 3, out_ready[3]=0 for 3 cycles then 1 -> out_valid=8'h08 and out_data stable 3 cycles, delivered on 4th; in_ready 0 while waiting, 1 in fire cycle.
REQ-034 TIMEOUT=16, out_ready=0, one word -> out_valid drops after 16 cycles, drop_cnt 0->1; 300 such words -> drop_cnt saturates at 255.
REQ-035 Held word for channel 1, clear en_mask bit 1 mid-HOLD -> still delivered on channel 1; en_mask=0 -> in_ready 0.
REQ-036 Assert rst during HOLD -> out_valid 0 same cycle, drop_cnt unchanged at 0, next word after release goes to channel 0.
